// File: rtl/card_pkg.sv
// Shared card/display constants and sequencer state type for the hand display.
package card_pkg;
  localparam int unsigned NUM_CARDS = 52;
  localparam int unsigned CARD_W    = 6;
  localparam int unsigned DIGIT_W   = 5;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 5'd24;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } seq_state_e;
endpackage

// File: rtl/hand_display_seq_if.sv
// Card push handshake between game logic (master) and the hand sequencer (slave).
interface hand_display_seq_if;
  import card_pkg::*;

  logic              push_valid;
  logic [CARD_W-1:0] push_card;
  logic              push_ready;

  modport master (output push_valid, push_card, input  push_ready);
  modport slave  (input  push_valid, push_card, output push_ready);
endinterface

// File: rtl/digit_scanner.sv
// Four-anode scan: free-running slot counter, registered anode decode and digit mux.
module digit_scanner
  import card_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES = 100_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [DIGIT_W-1:0] dig1,
  input  logic [DIGIT_W-1:0] dig2,
  input  logic [DIGIT_W-1:0] dig3,
  input  logic [DIGIT_W-1:0] dig4,
  output logic [DIGIT_W-1:0] seg_code,
  output logic [3:0]         an
);
  localparam int unsigned SW = $clog2(SCAN_CYCLES + 1);

  logic [SW-1:0] scan_cnt;
  logic [1:0]    dig_sel;
  logic [1:0]    sel_q;
  logic          on_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_sel  <= '0;
      sel_q    <= '0;
      on_q     <= 1'b0;
      an       <= '1;
    end else if (clr) begin
      scan_cnt <= '0;
      dig_sel  <= '0;
      sel_q    <= '0;
      on_q     <= 1'b0;
      an       <= '1;
    end else begin
      if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
        scan_cnt <= '0;
        dig_sel  <= dig_sel + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      sel_q <= dig_sel;
      on_q  <= en;
      an    <= en ? ~(4'b0001 << dig_sel) : '1;
    end
  end

  // Mux select is registered alongside the anodes, so the live converter digits
  // always land on the anode that is currently lit.
  always_comb begin
    seg_code = BLANK_CODE;
    if (on_q) begin
      case (sel_q)
        2'd0:    seg_code = dig1;
        2'd1:    seg_code = dig2;
        2'd2:    seg_code = dig3;
        default: seg_code = dig4;
      endcase
    end
  end
endmodule

// File: rtl/hand_display_seq.sv
// Player-hand display sequencer: stores pushed cards, rotates them through the converter, scans digits.
// Optional macro HAND_DISPLAY_BLANK_EN inserts a blanked gap before each card change.
module hand_display_seq
  import card_pkg::*;
#(
  parameter int unsigned MAX_CARDS    = 8,
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter int unsigned SCAN_CYCLES  = 100_000,
  parameter int unsigned BLANK_CYCLES = 10_000_000,
  localparam int unsigned CW = $clog2(MAX_CARDS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  hand_display_seq_if.slave   push,
  input  logic                pause,
  output logic [CARD_W-1:0]   card_out,
  input  logic [DIGIT_W-1:0]  dig1,
  input  logic [DIGIT_W-1:0]  dig2,
  input  logic [DIGIT_W-1:0]  dig3,
  input  logic [DIGIT_W-1:0]  dig4,
  output logic [DIGIT_W-1:0]  seg_code,
  output logic [3:0]          an,
  output logic [CW-1:0]       count,
  output logic                err
);
  localparam int unsigned IW = $clog2(MAX_CARDS);
  localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);

  seq_state_e        state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [DW-1:0]     dwell, dwell_nxt;
  logic [CARD_W-1:0] slot [MAX_CARDS];
  logic              take, store, bad;

`ifdef HAND_DISPLAY_BLANK_EN
  localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);
  logic [BW-1:0] blk, blk_nxt;
`endif

  assign push.push_ready = (count < CW'(MAX_CARDS)) & ~clr;
  assign take  = push.push_valid & push.push_ready;
  assign store = take & (push.push_card < CARD_W'(NUM_CARDS));
  assign bad   = take & ~store;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dwell_nxt = dwell;
`ifdef HAND_DISPLAY_BLANK_EN
    blk_nxt   = blk;
`endif
    if (clr) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      dwell_nxt = '0;
`ifdef HAND_DISPLAY_BLANK_EN
      blk_nxt   = '0;
`endif
    end else begin
      case (state)
        IDLE: if (store) state_nxt = SHOW;
        SHOW: if (!pause) begin
          if (dwell == DW'(DWELL_CYCLES - 1)) begin
            dwell_nxt = '0;
            idx_nxt   = ((CW'(idx) + CW'(1)) >= count) ? '0 : idx + IW'(1);
`ifdef HAND_DISPLAY_BLANK_EN
            state_nxt = BLANK;
`endif
          end else begin
            dwell_nxt = dwell + DW'(1);
          end
        end
`ifdef HAND_DISPLAY_BLANK_EN
        BLANK: if (!pause) begin
          if (blk == BW'(BLANK_CYCLES - 1)) begin
            blk_nxt   = '0;
            state_nxt = SHOW;
          end else begin
            blk_nxt = blk + BW'(1);
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      dwell    <= '0;
      count    <= '0;
      err      <= 1'b0;
      card_out <= '0;
`ifdef HAND_DISPLAY_BLANK_EN
      blk      <= '0;
`endif
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      dwell <= dwell_nxt;
      err   <= bad;
`ifdef HAND_DISPLAY_BLANK_EN
      blk   <= blk_nxt;
`endif
      if (clr) begin
        count    <= '0;
        card_out <= '0;
      end else begin
        if (store) count <= count + CW'(1);
        // New cards land at slot[count] > idx, so only idx moves change card_out.
        if (state != IDLE) card_out <= slot[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) slot[count[IW-1:0]] <= push.push_card;
  end

  digit_scanner #(
    .SCAN_CYCLES (SCAN_CYCLES)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .en       (state == SHOW),
    .dig1     (dig1),
    .dig2     (dig2),
    .dig3     (dig3),
    .dig4     (dig4),
    .seg_code (seg_code),
    .an       (an)
  );
endmodule

// File: tb/tb_hand_display_seq.sv
// Directed bench for hand_display_seq with a queue-based hand model checked every cycle.
module tb_hand_display_seq;
  localparam int MAXC   = 4;
  localparam int DWELL  = 4;
  localparam int SCAN   = 2;
  localparam int BLANKC = 2;
`ifdef HAND_DISPLAY_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       pause = 1'b0;
  logic [5:0] card_out;
  logic [4:0] dig1, dig2, dig3, dig4, seg_code;
  logic [3:0] an;
  logic [2:0] count;
  logic       err;

  int n_checks = 0;
  int n_fail = 0;

  hand_display_seq_if pif ();

  hand_display_seq #(
    .MAX_CARDS    (MAXC),
    .DWELL_CYCLES (DWELL),
    .SCAN_CYCLES  (SCAN),
    .BLANK_CYCLES (BLANKC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (pif),
    .pause    (pause),
    .card_out (card_out),
    .dig1     (dig1),
    .dig2     (dig2),
    .dig3     (dig3),
    .dig4     (dig4),
    .seg_code (seg_code),
    .an       (an),
    .count    (count),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Stand-in converter: disjoint code ranges per digit position.
  function automatic logic [4:0] conv(int pos, int c);
    case (pos)
      0:       return 5'(c % 13);
      1:       return 5'(13 + c / 13);
      2:       return 5'(17 + c % 5);
      default: return 5'(25 + c % 7);
    endcase
  endfunction

  assign dig1 = conv(0, int'(card_out));
  assign dig2 = conv(1, int'(card_out));
  assign dig3 = conv(2, int'(card_out));
  assign dig4 = conv(3, int'(card_out));

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: hand as a queue, rotation position, elapsed dwell/blank time, scan time.
  int         hand[$];
  int         m_state;  // 0 idle, 1 showing, 2 blank gap
  int         m_pos, m_dw, m_bk, m_scan;
  int         e_card, e_sel;
  logic [3:0] e_an;
  bit         e_err;

  task automatic model_reset();
    hand.delete();
    m_state = 0; m_pos = 0; m_dw = 0; m_bk = 0; m_scan = 0;
    e_card = 0; e_sel = 0; e_an = 4'hF; e_err = 1'b0;
  endtask

  task automatic model_step();
    bit rdy;
    int sel0;
    rdy  = (hand.size() < MAXC) && !clr;
    sel0 = (m_scan / SCAN) % 4;
    if (clr) begin
      model_reset();
    end else begin
      e_an   = (m_state == 1) ? 4'(~(4'b0001 << sel0)) : 4'hF;
      e_sel  = sel0;
      m_scan = (m_scan + 1) % (4 * SCAN);
      if (m_state != 0) e_card = hand[m_pos];
      e_err = pif.push_valid && rdy && (pif.push_card >= 6'd52);
      if (m_state == 1 && !pause) begin
        m_dw++;
        if (m_dw == DWELL) begin
          m_dw  = 0;
          m_pos = (m_pos + 1 >= hand.size()) ? 0 : m_pos + 1;
          if (BLANK_EN) m_state = 2;
        end
      end else if (m_state == 2 && !pause) begin
        m_bk++;
        if (m_bk == BLANKC) begin
          m_bk = 0;
          m_state = 1;
        end
      end
      if (pif.push_valid && rdy && (pif.push_card < 6'd52)) begin
        hand.push_back(int'(pif.push_card));
        if (m_state == 0) m_state = 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  logic [4:0] e_seg;
  always @(negedge clk) begin
    e_seg = (e_an == 4'hF) ? 5'd24 : conv(e_sel, e_card);
    chk("count", int'(count), hand.size());
    chk("push_ready", int'(pif.push_ready), int'((hand.size() < MAXC) && !clr));
    chk("err", int'(err), int'(e_err));
    chk("card_out", int'(card_out), e_card);
    chk("an", int'(an), int'(e_an));
    chk("seg_code", int'(seg_code), int'(e_seg));
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(int c);
    pif.push_valid = 1'b1;
    pif.push_card  = 6'(c);
    cyc(1);
    pif.push_valid = 1'b0;
  endtask

  initial begin
    pif.push_valid = 1'b0;
    pif.push_card  = '0;
    model_reset();
    cyc(2);
    rst_n = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_an", int'(an), 15);
    chk("rst_seg", int'(seg_code), 24);
    chk("rst_card", int'(card_out), 0);
    chk("rst_ready", int'(pif.push_ready), 1);
    chk("rst_err", int'(err), 0);
    cyc(3);

    push(5);
    chk("count_first", int'(count), 1);
    cyc(1);
    chk("card_first", int'(card_out), 5);

    push(52);
    chk("err_pulse", int'(err), 1);
    chk("count_bad", int'(count), 1);
    chk("ready_bad", int'(pif.push_ready), 1);
    cyc(1);
    chk("err_once", int'(err), 0);
    cyc(8);

    push(0);
    push(13);
    push(51);
    chk("count_full", int'(count), 4);
    push(7);
    chk("ready_full", int'(pif.push_ready), 0);
    chk("count_held", int'(count), 4);
    cyc(30);

    cyc(2);
    pause = 1'b1;
    cyc(10);
    pause = 1'b0;
    cyc(12);

    clr = 1'b1;
    pif.push_valid = 1'b1;
    pif.push_card  = 6'd9;
    cyc(1);
    clr = 1'b0;
    pif.push_valid = 1'b0;
    chk("clr_count", int'(count), 0);
    chk("clr_an", int'(an), 15);
    chk("clr_card", int'(card_out), 0);
    cyc(2);
    chk("idle_an", int'(an), 15);

    push(22);
    push(40);
    cyc(9);
    rst_n = 1'b0;
    #1;
    chk("async_an", int'(an), 15);
    chk("async_seg", int'(seg_code), 24);
    chk("async_count", int'(count), 0);
    chk("async_card", int'(card_out), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    push(3);
    cyc(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
